cmd_queue: RTL and testbench

Command FIFO that sits between the host/testbench command source and the issuer. It completes the issuer's queue read interface: it drives the cmd_t and empty signals into the issuer and consumes the issuer's read strobe. It is first-word-fall-through, so the head command is always visible while the queue is non-empty. It instantiates in top in place of the external queue_cmd/queue_empty inputs.

---
 rtl/cmd_queue_pkg.sv | 15 +
 rtl/cmd_queue.sv | 86 ++++++++
 tb/tb_cmd_queue.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/cmd_queue_pkg.sv
// Shared command-path types. The queue treats cmd_t as an opaque bit vector.
package cmd_queue_pkg;

  typedef logic [7:0]  instr_t;
  typedef logic [15:0] addr_t;

  typedef struct packed {
    instr_t instr;
    addr_t  addr;
  } cmd_t;

  // Default command queue depth; top passes this as DEPTH.
  localparam int unsigned CMDQ_DEPTH = 16;

endpackage

// File: rtl/cmd_queue.sv
// First-word-fall-through command FIFO between the command source and the issuer.
// Head entry is visible on o_cmd whenever the queue is non-empty.
module cmd_queue
  import cmd_queue_pkg::*;
#(
  parameter int unsigned DEPTH = CMDQ_DEPTH,
  parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic             i_wr,
  input  cmd_t             i_cmd,
  output logic             o_full,
  input  logic             i_rd,
  output cmd_t             o_cmd,
  output logic             o_empty,
  input  logic             i_flush,
  output logic [CNT_W-1:0] o_count,
  output logic             o_overflow,
  output logic             o_underflow
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  cmd_t             mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;
  logic             do_wr, do_rd;

  // Status comes only from registered count, never from the strobes.
  assign o_empty     = (count_q == '0);
  assign o_full      = (count_q == CNT_W'(DEPTH));
  assign o_count     = count_q;
  assign o_overflow  = overflow_q;
  assign o_underflow = underflow_q;
  assign o_cmd       = o_empty ? cmd_t'('0) : mem[rd_ptr_q];

  // Popping while full frees a slot for the same-cycle push.
  assign do_wr = i_wr & (~o_full | i_rd);
  assign do_rd = i_rd & ~o_empty;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (i_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_wr) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_rd) rd_ptr_d = rd_ptr_q + 1'b1;
      if (do_wr && !do_rd)      count_d = count_q + 1'b1;
      else if (do_rd && !do_wr) count_d = count_q - 1'b1;
      if (i_wr && o_full && !i_rd) overflow_d  = 1'b1;
      if (i_rd && o_empty)         underflow_d = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge i_clk) begin
    if (do_wr && !i_flush) mem[wr_ptr_q] <= i_cmd;
  end

endmodule

// File: tb/tb_cmd_queue.sv
// Directed self-checking bench for cmd_queue at DEPTH=4.
module tb_cmd_queue;
  import cmd_queue_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CNT_W = 3;

  logic             clk = 1'b0;
  logic             rstn;
  logic             wr, rd, flush;
  cmd_t             cmd_in;
  logic             full, empty, overflow, underflow;
  cmd_t             cmd_out;
  logic [CNT_W-1:0] count;

  int n_checks = 0;
  int n_errors = 0;

  cmd_queue #(.DEPTH(DEPTH)) dut (
    .i_clk      (clk),
    .i_rstn     (rstn),
    .i_wr       (wr),
    .i_cmd      (cmd_in),
    .o_full     (full),
    .i_rd       (rd),
    .o_cmd      (cmd_out),
    .o_empty    (empty),
    .i_flush    (flush),
    .o_count    (count),
    .o_overflow (overflow),
    .o_underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input cmd_t v);
    wr = 1'b1; cmd_in = v;
    tick();
    wr = 1'b0;
  endtask

  task automatic pop_expect(input string tag, input cmd_t v);
    rd = 1'b1;
    check(tag, 32'(cmd_out), 32'(v));
    tick();
    rd = 1'b0;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    #7;
    rstn = 1'b1;
    tick();
  endtask

  cmd_t vals [5];
  int   pop_idx;

  initial begin
    vals[0] = 24'hA0_000A; vals[1] = 24'hB1_000B; vals[2] = 24'hC2_000C;
    vals[3] = 24'hD3_000D; vals[4] = 24'hE4_000E;
    wr = 0; rd = 0; flush = 0; cmd_in = '0; rstn = 1'b1;
    #2;
    rstn = 1'b0;
    #1;
    check("rst_empty", 32'(empty), 1);
    check("rst_full", 32'(full), 0);
    check("rst_count", 32'(count), 0);
    check("rst_cmd", 32'(cmd_out), 0);
    check("rst_ovf", 32'(overflow), 0);
    check("rst_unf", 32'(underflow), 0);
    #5 rstn = 1'b1;
    tick();

    // Fill, then overflow with E.
    for (int i = 0; i < 4; i++) push(vals[i]);
    check("fill_full", 32'(full), 1);
    check("fill_count", 32'(count), 4);
    check("fill_head", 32'(cmd_out), 32'(vals[0]));
    push(vals[4]);
    check("ovf_flag", 32'(overflow), 1);
    check("ovf_count", 32'(count), 4);
    check("ovf_head", 32'(cmd_out), 32'(vals[0]));

    // Drain order and underflow.
    for (int i = 0; i < 4; i++) pop_expect($sformatf("drain%0d", i), vals[i]);
    check("drain_empty", 32'(empty), 1);
    check("drain_count", 32'(count), 0);
    check("drain_cmd", 32'(cmd_out), 0);
    check("pre_unf", 32'(underflow), 0);
    rd = 1'b1; tick(); rd = 1'b0;
    check("unf_flag", 32'(underflow), 1);
    check("unf_count", 32'(count), 0);

    // Simultaneous push and pop while full.
    for (int i = 0; i < 4; i++) push(vals[i]);
    wr = 1'b1; rd = 1'b1; cmd_in = vals[4];
    check("fullsim_head", 32'(cmd_out), 32'(vals[0]));
    tick();
    wr = 1'b0; rd = 1'b0;
    check("fullsim_count", 32'(count), 4);
    for (int i = 1; i < 5; i++) pop_expect($sformatf("fullsim_drain%0d", i), vals[i]);
    check("fullsim_empty", 32'(empty), 1);

    // Simultaneous push and pop while empty.
    do_reset();
    check("rst2_unf", 32'(underflow), 0);
    check("rst2_ovf", 32'(overflow), 0);
    wr = 1'b1; rd = 1'b1; cmd_in = 24'h5A_5A5A;
    tick();
    wr = 1'b0; rd = 1'b0;
    check("emptysim_count", 32'(count), 1);
    check("emptysim_head", 32'(cmd_out), 32'h5A5A5A);
    check("emptysim_unf", 32'(underflow), 1);
    pop_expect("emptysim_pop", 24'h5A_5A5A);

    // Wrap-around: 10 values through occupancy 1..3.
    pop_idx = 0;
    for (int v = 0; v < 3; v++) push(cmd_t'(v));
    check("wrap_occ3", 32'(count), 3);
    for (int v = 3; v < 10; v++) begin
      wr = 1'b1; rd = 1'b1; cmd_in = cmd_t'(v);
      check($sformatf("wrap_pop%0d", pop_idx), 32'(cmd_out), pop_idx);
      tick();
      pop_idx++;
      wr = 1'b0; rd = 1'b0;
      check($sformatf("wrap_cnt%0d", v), 32'(count), 3);
    end
    while (pop_idx < 10) begin
      pop_expect($sformatf("wrap_pop%0d", pop_idx), cmd_t'(pop_idx));
      pop_idx++;
    end
    check("wrap_empty", 32'(empty), 1);

    // Flush with simultaneous push; flags retained.
    for (int i = 0; i < 4; i++) push(vals[i]);
    push(vals[4]);
    pop_expect("flush_prep", vals[0]);
    check("flush_pre_count", 32'(count), 3);
    flush = 1'b1; wr = 1'b1; cmd_in = vals[4];
    tick();
    flush = 1'b0; wr = 1'b0;
    check("flush_empty", 32'(empty), 1);
    check("flush_count", 32'(count), 0);
    check("flush_cmd", 32'(cmd_out), 0);
    check("flush_ovf", 32'(overflow), 1);
    check("flush_unf", 32'(underflow), 1);
    push(24'h11_2233);
    check("flush_push", 32'(cmd_out), 32'h112233);

    // Asynchronous reset mid-cycle.
    push(vals[1]);
    push(vals[2]);
    #2 rstn = 1'b0;
    #1;
    check("arst_empty", 32'(empty), 1);
    check("arst_count", 32'(count), 0);
    check("arst_cmd", 32'(cmd_out), 0);
    check("arst_ovf", 32'(overflow), 0);
    check("arst_unf", 32'(underflow), 0);
    #3 rstn = 1'b1;
    tick();
    push(vals[3]);
    check("arst_push", 32'(cmd_out), 32'(vals[3]));
    check("arst_count1", 32'(count), 1);
    pop_expect("arst_pop", vals[3]);
    check("arst_final_empty", 32'(empty), 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

endmodule
